// File: rtl/mem_access_unit.sv
// Data-memory initiator: turns CPU load/store requests into single-port data_mem accesses.
// Optional MAU_PERF_CNT_EN adds load_count/store_count outputs.
module mem_access_unit #(
  parameter logic [63:0] DATA_START = 64'h1000_0000_0000_0000,
  parameter logic [63:0] DATA_BYTES = 64'h0000_0000_0080_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_word_we,
  output logic        mem_byte_we,
  input  logic [63:0] mem_rdata
`ifdef MAU_PERF_CNT_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count
`endif
);

  localparam logic [63:0] DATA_END = DATA_START + DATA_BYTES;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t      state, state_n;
  logic        lat_write, lat_signed;
  logic [1:0]  lat_size;
  logic [63:0] lat_addr, lat_wdata;

  logic        req_mis, req_flt;
  logic        resp_valid_n, mis_n, flt_n;
  logic [63:0] resp_rdata_n, mem_addr_n, mem_wdata_n;
  logic        word_we_n, byte_we_n;
  logic [5:0]  lane_sh;
  logic [63:0] lane, load_val, ins_mask, merged;

  assign req_ready = (state == IDLE);

  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      2'd0: req_mis = 1'b0;
      2'd1: req_mis = req_addr[0];
      2'd2: req_mis = |req_addr[1:0];
      default: req_mis = |req_addr[2:0];
    endcase
    req_flt = (req_addr < DATA_START) || (req_addr >= DATA_END);
  end

  always_comb begin
    lane_sh  = {lat_addr[2:0], 3'b000};
    lane     = mem_rdata >> lane_sh;
    load_val = lane;
    case (lat_size)
      2'd0: load_val = lat_signed ? {{56{lane[7]}}, lane[7:0]} : {56'd0, lane[7:0]};
      2'd1: load_val = lat_signed ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
      2'd2: load_val = lat_signed ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
      default: load_val = lane;
    endcase
    ins_mask = (lat_size == 2'd1) ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_FFFF_FFFF;
    merged   = (mem_rdata & ~(ins_mask << lane_sh)) | ((lat_wdata & ins_mask) << lane_sh);
  end

  // All memory-side and response outputs are registered one state ahead, so the
  // merged write word is formed from mem_rdata at the end of ACCESS and held in mem_wdata.
  always_comb begin
    state_n      = state;
    resp_valid_n = 1'b0;
    mis_n        = 1'b0;
    flt_n        = 1'b0;
    resp_rdata_n = resp_rdata;
    mem_addr_n   = '0;
    mem_wdata_n  = '0;
    word_we_n    = 1'b0;
    byte_we_n    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          resp_rdata_n = '0;
          if (req_mis || req_flt) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            mis_n        = req_mis;
            flt_n        = req_flt;
          end else begin
            state_n    = ACCESS;
            mem_addr_n = {req_addr[63:3], 3'b000};
            if (req_write && req_size == 2'd0) begin
              mem_addr_n  = req_addr;
              mem_wdata_n = req_wdata;
              byte_we_n   = 1'b1;
            end else if (req_write && req_size == 2'd3) begin
              mem_wdata_n = req_wdata;
              word_we_n   = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
        if (!lat_write) begin
          resp_rdata_n = load_val;
        end else if (lat_size == 2'd1 || lat_size == 2'd2) begin
          state_n      = MERGE;
          resp_valid_n = 1'b0;
          mem_addr_n   = {lat_addr[63:3], 3'b000};
          mem_wdata_n  = merged;
          word_we_n    = 1'b1;
        end
      end
      MERGE: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      lat_write       <= 1'b0;
      lat_signed      <= 1'b0;
      lat_size        <= '0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
      resp_rdata      <= '0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_word_we     <= 1'b0;
      mem_byte_we     <= 1'b0;
    end else begin
      state           <= state_n;
      resp_valid      <= resp_valid_n;
      resp_misaligned <= mis_n;
      resp_fault      <= flt_n;
      resp_rdata      <= resp_rdata_n;
      mem_addr        <= mem_addr_n;
      mem_wdata       <= mem_wdata_n;
      mem_word_we     <= word_we_n;
      mem_byte_we     <= byte_we_n;
      if (state == IDLE && req_valid) begin
        lat_write  <= req_write;
        lat_signed <= req_signed;
        lat_size   <= req_size;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
      end
    end
  end

`ifdef MAU_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (resp_valid && !resp_misaligned && !resp_fault) begin
      if (lat_write) store_count <= store_count + 32'd1;
      else           load_count  <= load_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level reference memory, directed and random requests.
module tb_mem_access_unit;

  localparam logic [63:0] DS = 64'h1000_0000_0000_0000;
  localparam logic [63:0] DB = 64'h0000_0000_0080_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_fault;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_word_we, mem_byte_we;
`ifdef MAU_PERF_CNT_EN
  logic [31:0] load_count, store_count;
`endif
  int unsigned exp_loads = 0, exp_stores = 0;

  int tests = 0;
  int fails = 0;

  logic [63:0] dm [0:31];
  logic [7:0]  ref_b [0:255];

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_START(DS), .DATA_BYTES(DB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_word_we(mem_word_we), .mem_byte_we(mem_byte_we), .mem_rdata(mem_rdata)
`ifdef MAU_PERF_CNT_EN
    , .load_count(load_count), .store_count(store_count)
`endif
  );

  // data_mem stand-in: combinational read, negedge write; 256 bytes aliased over the window
  assign mem_rdata = dm[mem_addr[7:3]];
  always @(negedge clk) begin
    if (mem_word_we) dm[mem_addr[7:3]] = mem_wdata;
    if (mem_byte_we) dm[mem_addr[7:3]][{mem_addr[2:0], 3'b000} +: 8] = mem_wdata[7:0];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input int w);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_b[w*8 + i];
    return v;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] a, input int sz, input bit sg);
    int n = 1 << sz;
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[int'(a[7:0]) + i];
    if (sg && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic m_store(input logic [63:0] a, input int sz, input logic [63:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_b[int'(a[7:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic garbage_req();
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = DS + 64'($urandom_range(0, 255));
    req_wdata  = {$urandom, $urandom};
  endtask

  task automatic do_req(input bit wr, input int sz, input bit sg, input logic [63:0] a,
                        input logic [63:0] wd, output logic [63:0] rd_out);
    bit mis, flt, ok;
    int exp_lat, got, wcnt, bcnt, both, g;
    logic [63:0] exp_rd, got_rd;
    logic got_mis, got_flt;
    mis = (a % (64'd1 << sz)) != 0;
    flt = (a < DS) || (a >= DS + DB);
    ok  = !mis && !flt;
    exp_lat = !ok ? 1 : (wr && (sz == 1 || sz == 2)) ? 3 : 2;
    exp_rd  = (ok && !wr) ? m_load(a, sz, sg) : 64'd0;
    got = 0; wcnt = 0; bcnt = 0; both = 0; g = 0;
    got_rd = '0; got_mis = 1'b0; got_flt = 1'b0;
    rd_out = '0;
    @(negedge clk);
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    if (!req_ready) begin
      chk("ready_timeout", {63'd0, req_ready}, 64'd1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = 2'(sz); req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    for (int n = 1; n <= 8 && got == 0; n++) begin
      @(negedge clk);
      if (mem_word_we) begin
        wcnt++;
        chk("word_we_addr", mem_addr, {a[63:3], 3'b000});
      end
      if (mem_byte_we) begin
        bcnt++;
        chk("byte_we_addr", mem_addr, a);
        chk("byte_we_data", {56'd0, mem_wdata[7:0]}, {56'd0, wd[7:0]});
      end
      if (mem_word_we && mem_byte_we) both++;
      if (resp_valid) begin
        got = n; got_rd = resp_rdata; got_mis = resp_misaligned; got_flt = resp_fault;
        chk("ready_busy", {63'd0, req_ready}, 64'd0);
        req_valid = 1'b0;
      end else begin
        // requester keeps presenting unrelated requests while busy; they must be ignored
        garbage_req();
      end
    end
    req_valid = 1'b0;
    chk("latency", 64'(got), 64'(exp_lat));
    chk("rdata", got_rd, exp_rd);
    chk("misaligned", {63'd0, got_mis}, {63'd0, mis});
    chk("fault", {63'd0, got_flt}, {63'd0, flt});
    chk("word_we_cnt", 64'(wcnt), (ok && wr && sz != 0) ? 64'd1 : 64'd0);
    chk("byte_we_cnt", 64'(bcnt), (ok && wr && sz == 0) ? 64'd1 : 64'd0);
    chk("both_we", 64'(both), 64'd0);
    if (ok && wr) m_store(a, sz, wd);
    if (ok) begin
      if (wr) exp_stores++;
      else    exp_loads++;
    end
    @(negedge clk);
    chk("resp_pulse", {63'd0, resp_valid}, 64'd0);
    chk("ready_after", {63'd0, req_ready}, 64'd1);
    chk("mem_word", dm[a[7:3]], ref_word(int'(a[7:3])));
    rd_out = got_rd;
  endtask

  logic [63:0] rd;

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int w = 0; w < 32; w++) begin
      dm[w] = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) ref_b[w*8 + i] = dm[w][8*i +: 8];
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_flags", {62'd0, resp_misaligned, resp_fault}, 64'd0);
    chk("rst_we", {62'd0, mem_word_we, mem_byte_we}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    reset = 1'b1;

    do_req(1, 3, 0, DS, 64'hF0E0D0C0B0A09080, rd);
    do_req(0, 0, 1, DS, 64'd0, rd);      chk("lb_lit", rd, 64'hFFFFFFFFFFFFFF80);
    do_req(0, 0, 0, DS, 64'd0, rd);      chk("lbu_lit", rd, 64'h0000000000000080);
    do_req(0, 1, 1, DS + 2, 64'd0, rd);  chk("lh_lit", rd, 64'hFFFFFFFFFFFFB0A0);
    do_req(0, 2, 0, DS + 4, 64'd0, rd);  chk("lwu_lit", rd, 64'h00000000F0E0D0C0);
    do_req(1, 3, 0, DS, 64'h1122334455667788, rd);
    do_req(1, 2, 0, DS + 4, 64'h00000000DEADBEEF, rd);
    chk("sw_lit", dm[0], 64'hDEADBEEF55667788);
    do_req(0, 3, 0, DS, 64'd0, rd);      chk("ld_lit", rd, 64'hDEADBEEF55667788);
    do_req(1, 1, 0, DS + 1, 64'h1234, rd);
    do_req(0, 3, 0, 64'd0, 64'd0, rd);
    do_req(1, 3, 0, DS, 64'h1122334455667788, rd);
    do_req(1, 0, 0, DS + 3, 64'h00000000000000AB, rd);
    chk("sb_lit", dm[0], 64'h11223344AB667788);
    do_req(0, 3, 0, DS + DB - 8, 64'd0, rd);
    do_req(0, 3, 0, DS + DB, 64'd0, rd);
    do_req(1, 0, 0, DS - 1, 64'hFF, rd);

    for (int k = 0; k < 250; k++) begin
      bit wr, sg;
      int sz, r;
      logic [63:0] a;
      wr = 1'($urandom); sg = 1'($urandom); sz = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 15));
      a = DS + 64'($urandom_range(0, 255));
      if (r < 11) a = a & ~((64'd1 << sz) - 64'd1);
      else if (r == 14) a = DS - 64'($urandom_range(1, 64));
      else if (r == 15) a = DS + DB + 64'($urandom_range(0, 64));
      do_req(wr, sz, sg, a, {$urandom, $urandom}, rd);
    end

`ifdef MAU_PERF_CNT_EN
    chk("load_count", {32'd0, load_count}, {32'd0, 32'(exp_loads)});
    chk("store_count", {32'd0, store_count}, {32'd0, 32'(exp_stores)});
`endif

    // reset during the merge write of a half store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = DS + 18; req_wdata = 64'h0000_0000_0000_5A5A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("merge_we", {63'd0, mem_word_we}, 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_we", {62'd0, mem_word_we, mem_byte_we}, 64'd0);
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_loads = 0; exp_stores = 0;
    @(negedge clk);
    chk("rst_rel_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_mem_kept", dm[2], ref_word(2));
`ifdef MAU_PERF_CNT_EN
    chk("cnt_rst", {load_count, store_count}, 64'd0);
`endif
    do_req(0, 1, 0, DS + 18, 64'd0, rd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
